tile_loader: RTL and testbench
==============================

# tile_loader

Memory-side initiator that fills a local N×N operand tile, either the weight matrix W or the input matrix X, from the fixed-latency memory port. It issues one read at a time, waits a fixed latency, captures each response beat into an internal tile buffer and signals completion. Downstream, the systolic-array feed logic reads the tile through a registered read port. It drives the same request/response signals the memory responder accepts.

## Interface
Parameters:
- N, 4, tile dimension; tile holds N*N elements
- DATA_WIDTH, 16, element width in bits; must be a multiple of 8
- BANKING_FACTOR, 1, elements per memory beat; N*N must be divisible by it
- ADDRESS_WIDTH, 13, memory byte-address width
- BASE_ADDR_W, 'h0000, byte base address of W
- BASE_ADDR_X, 'h1000, byte base address of X
- MEM_LATENCY, 2, responder latency in cycles, ≥1

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle load request
- sel_x  in  1  sampled with start: 0 = load W, 1 = load X
- busy  out  1  load in progress
- done  out  1  one-cycle pulse when the tile is complete
- mem_read_en  out  1  read request strobe
- mem_req_addr  out  ADDRESS_WIDTH  byte address of the request
- mem_write_en  out  1  tied 0
- mem_req_data  out  DATA_WIDTH*BANKING_FACTOR  tied 0
- mem_resp_data  in  DATA_WIDTH*BANKING_FACTOR  response beat, registered by the responder
- buf_rd_en  in  1  tile buffer read strobe
- buf_rd_idx  in  $clog2(N*N)  element index, row-major
- buf_rd_data  out  DATA_WIDTH  element read data

## Operation
- BEATS = N*N/BANKING_FACTOR. STRIDE = BANKING_FACTOR*DATA_WIDTH/8 bytes.
- FSM states: IDLE, REQ, WAIT, CAP, DONE.
- IDLE: when start=1, latch base (BASE_ADDR_X if sel_x, else BASE_ADDR_W), clear the beat counter and go to REQ.
- REQ: mem_read_en=1, mem_req_addr = base + beat*STRIDE (modulo 2^ADDRESS_WIDTH). Go to WAIT with the wait counter cleared.
- WAIT: mem_read_en=0. Stay MEM_LATENCY cycles, then go to CAP.
- CAP: write mem_resp_data[b*DATA_WIDTH +: DATA_WIDTH] to buffer index beat*BANKING_FACTOR+b for every b. If this was the last beat (BEATS-1), go to DONE; otherwise increment beat and go to REQ.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- Only one request is outstanding at any time; mem_read_en is never high outside REQ.
- busy=1 in REQ, WAIT and CAP; busy=0 in IDLE and DONE.
- start is ignored in every state except IDLE. It is also ignored in the DONE cycle.
- Buffer read port: when buf_rd_en=1, buf_rd_data takes buffer[buf_rd_idx] on the next edge; otherwise it holds its value. Reads are legal at any time.
- A read of an index being written in the same CAP cycle returns the old value.
- The buffer is not reset. Its contents persist across loads until overwritten.

## Timing
- Reset values: busy=0, done=0, mem_read_en=0, mem_req_addr=0, buf_rd_data=0, state=IDLE.
- rst asserted mid-load aborts immediately: no done pulse, and mem_read_en drops asynchronously.
- Responder contract: a request sampled at edge k yields valid mem_resp_data from edge k+MEM_LATENCY+1. CAP samples at that edge.
- Beat period = MEM_LATENCY+2 cycles.
- start sampled at edge 0: REQ occupies cycle 0→1. The last CAP ends at edge BEATS*(MEM_LATENCY+2). done is high for the following cycle.
- Total start-to-done latency = BEATS*(MEM_LATENCY+2) cycles. Example: N=4, BANKING_FACTOR=1, MEM_LATENCY=2 gives 64 cycles.
- buf_rd_data latency is 1 cycle.

## Test plan
- Load W (N=4, BF=1, L=2), responder holding weight element i = 0x0100*i: exactly 16 requests at addresses 0x0000, 0x0002, … 0x001E, each mem_read_en one cycle wide and 4 cycles apart. done fires at start+64. Reading idx 5 returns 0x0500.
- Load X with sel_x=1: first address 0x1000, last 0x101E. Buffer receives the X pattern, overwriting the prior W data.
- BANKING_FACTOR=2, responder packing {elem 2k+1, elem 2k}: 8 requests with stride 4 bytes. Buffer idx 2k and 2k+1 hold the low and high halves respectively. done fires at start+32.
- start pulsed again during a load and during the DONE cycle: ignored. The address sequence is undisturbed and exactly one done pulse occurs.
- rst asserted after the 3rd request: busy, mem_read_en and done go 0 immediately. A new start after reset restarts at the base address.
- Same-cycle read of idx 0 while CAP writes idx 0: returns the old value. A read of idx 0 on the next cycle returns the new value.

Source files
------------

// File: rtl/tile_loader_if.sv
// Bundle of the tile loader's control, memory-request/response and tile
// buffer read signals. The slave view belongs to the loader itself; the
// master view is the side that starts loads, models the memory responder
// and reads the tile back.
interface tile_loader_if #(
    parameter int N              = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int BANKING_FACTOR = 1,
    parameter int ADDRESS_WIDTH  = 13
);
    localparam int IDX_W  = $clog2(N * N);
    localparam int BEAT_W = DATA_WIDTH * BANKING_FACTOR;

    logic                     start;
    logic                     sel_x;
    logic                     busy;
    logic                     done;
    logic                     mem_read_en;
    logic [ADDRESS_WIDTH-1:0] mem_req_addr;
    logic                     mem_write_en;
    logic [BEAT_W-1:0]        mem_req_data;
    logic [BEAT_W-1:0]        mem_resp_data;
    logic                     buf_rd_en;
    logic [IDX_W-1:0]         buf_rd_idx;
    logic [DATA_WIDTH-1:0]    buf_rd_data;

    modport master (
        output start, sel_x, mem_resp_data, buf_rd_en, buf_rd_idx,
        input  busy, done, mem_read_en, mem_req_addr, mem_write_en,
               mem_req_data, buf_rd_data
    );

    modport slave (
        input  start, sel_x, mem_resp_data, buf_rd_en, buf_rd_idx,
        output busy, done, mem_read_en, mem_req_addr, mem_write_en,
               mem_req_data, buf_rd_data
    );
endinterface

// File: rtl/tile_loader.sv
// Tile loader: fetches an N x N operand tile (W or X) from a fixed-latency
// memory port one beat at a time, stores it in a local buffer and pulses
// done when the last beat has been captured. The buffer is exposed through
// a registered read port for the array feed logic.
module tile_loader #(
    parameter int          N              = 4,
    parameter int          DATA_WIDTH     = 16,
    parameter int          BANKING_FACTOR = 1,
    parameter int          ADDRESS_WIDTH  = 13,
    parameter int unsigned BASE_ADDR_W    = 32'h0000_0000,
    parameter int unsigned BASE_ADDR_X    = 32'h0000_1000,
    parameter int          MEM_LATENCY    = 2
) (
    input  logic          clk,
    input  logic          rst,
    tile_loader_if.slave  bus
);
    localparam int ELEMS  = N * N;
    localparam int IDX_W  = $clog2(ELEMS);
    localparam int BEATS  = ELEMS / BANKING_FACTOR;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int STRIDE = BANKING_FACTOR * DATA_WIDTH / 8;
    localparam int WAIT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [BEAT_W-1:0]        BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [WAIT_W-1:0]        WAIT_LAST = WAIT_W'(MEM_LATENCY - 1);
    localparam logic [ADDRESS_WIDTH-1:0] BASE_W_C  = ADDRESS_WIDTH'(BASE_ADDR_W);
    localparam logic [ADDRESS_WIDTH-1:0] BASE_X_C  = ADDRESS_WIDTH'(BASE_ADDR_X);
    localparam logic [ADDRESS_WIDTH-1:0] STRIDE_C  = ADDRESS_WIDTH'(STRIDE);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_CAP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]               state_r;
    logic [2:0]               state_s;
    logic [BEAT_W-1:0]        beat_r;
    logic [BEAT_W-1:0]        beat_s;
    logic [WAIT_W-1:0]        wait_r;
    logic [WAIT_W-1:0]        wait_s;
    logic [ADDRESS_WIDTH-1:0] base_r;
    logic [ADDRESS_WIDTH-1:0] base_s;
    logic [ADDRESS_WIDTH-1:0] req_addr_s;

    logic                     busy_r;
    logic                     done_r;
    logic                     read_en_r;
    logic [ADDRESS_WIDTH-1:0] req_addr_r;
    logic [DATA_WIDTH-1:0]    rd_data_r;

    // Tile storage; deliberately not reset so a tile survives between loads.
    logic [DATA_WIDTH-1:0]    tile_mem_r [ELEMS];

    // Next-state, beat/wait counter and base address decode.
    always_comb begin
        state_s = state_r;
        beat_s  = beat_r;
        wait_s  = wait_r;
        base_s  = base_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_REQ;
                    beat_s  = '0;
                    base_s  = bus.sel_x ? BASE_X_C : BASE_W_C;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_s = ST_WAIT;
                wait_s  = '0;
            end
            ST_WAIT: begin
                if (wait_r == WAIT_LAST) begin
                    state_s = ST_CAP;
                end else begin
                    wait_s  = wait_r + WAIT_W'(1);
                end
            end
            ST_CAP: begin
                if (beat_r == BEAT_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_REQ;
                    beat_s  = beat_r + BEAT_W'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        req_addr_s = base_s + ADDRESS_WIDTH'(beat_s) * STRIDE_C;
    end

    // FSM and counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            beat_r  <= '0;
            wait_r  <= '0;
            base_r  <= '0;
        end else begin
            state_r <= state_s;
            beat_r  <= beat_s;
            wait_r  <= wait_s;
            base_r  <= base_s;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            read_en_r  <= 1'b0;
            req_addr_r <= '0;
        end else begin
            busy_r    <= (state_s == ST_REQ) || (state_s == ST_WAIT) ||
                         (state_s == ST_CAP);
            done_r    <= (state_s == ST_DONE);
            read_en_r <= (state_s == ST_REQ);
            if (state_s == ST_REQ) begin
                req_addr_r <= req_addr_s;
            end else begin
                req_addr_r <= req_addr_r;
            end
        end
    end

    // Capture every element of the response beat into the tile buffer.
    always_ff @(posedge clk) begin
        if (state_r == ST_CAP) begin
            for (int b = 0; b < BANKING_FACTOR; b++) begin
                tile_mem_r[IDX_W'(int'(beat_r) * BANKING_FACTOR + b)] <=
                    bus.mem_resp_data[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Registered buffer read port; a same-edge write is not forwarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= '0;
        end else if (bus.buf_rd_en) begin
            rd_data_r <= tile_mem_r[bus.buf_rd_idx];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.mem_read_en  = read_en_r;
    assign bus.mem_req_addr = req_addr_r;
    assign bus.mem_write_en = 1'b0;
    assign bus.mem_req_data = '0;
    assign bus.buf_rd_data  = rd_data_r;
endmodule

// File: tb/tb_tile_loader.sv
// Bench for tile_loader: one instance with BANKING_FACTOR=1 and one with
// BANKING_FACTOR=2, each behind a small latency-2 memory responder model.
// Expected request addresses/times are queued when a load is started and
// compared as the loader issues requests.
module tb_tile_loader;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Free-running cycle count used to time requests and done.
    always @(posedge clk) cyc <= cyc + 1;

    tile_loader_if #(.BANKING_FACTOR(1)) bus0 ();
    tile_loader_if #(.BANKING_FACTOR(2)) bus1 ();

    tile_loader #(.BANKING_FACTOR(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    tile_loader #(.BANKING_FACTOR(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Memory image: W element i = 0x0100*i at 2i; X element i = 0xA000+i at 0x1000+2i.
    function automatic logic [15:0] word(input logic [12:0] a);
        if (a >= 13'h1000) begin
            return 16'hA000 + 16'((a - 13'h1000) >> 1);
        end else begin
            return 16'(a >> 1) << 8;
        end
    endfunction

    // Responders: latency-2 pipelines on the request, registered data out.
    logic [1:0]  pv0, pv1;
    logic [12:0] pa0 [2];
    logic [12:0] pa1 [2];
    always @(posedge clk) begin
        pv0[0] <= bus0.mem_read_en;  pa0[0] <= bus0.mem_req_addr;
        pv0[1] <= pv0[0];            pa0[1] <= pa0[0];
        if (pv0[1]) bus0.mem_resp_data <= word(pa0[1]);
        pv1[0] <= bus1.mem_read_en;  pa1[0] <= bus1.mem_req_addr;
        pv1[1] <= pv1[0];            pa1[1] <= pa1[0];
        if (pv1[1]) bus1.mem_resp_data <= {word(pa1[1] + 13'd2), word(pa1[1])};
    end

    typedef struct {
        logic [12:0] a;
        int          c;
    } req_t;
    req_t q0[$];
    req_t q1[$];
    int   done_cnt0 = 0;
    int   done_cnt1 = 0;

    // Scoreboard side: every observed request must match the head entry.
    always @(negedge clk) begin
        req_t r;
        if (bus0.mem_read_en) begin
            if (q0.size() == 0) begin
                check("req0_unexpected", 32'd1, 32'd0);
            end else begin
                r = q0.pop_front();
                check("req0_addr", 32'(bus0.mem_req_addr), 32'(r.a));
                check("req0_time", cyc, r.c);
            end
        end
        if (bus1.mem_read_en) begin
            if (q1.size() == 0) begin
                check("req1_unexpected", 32'd1, 32'd0);
            end else begin
                r = q1.pop_front();
                check("req1_addr", 32'(bus1.mem_req_addr), 32'(r.a));
                check("req1_time", cyc, r.c);
            end
        end
        if (bus0.done) done_cnt0++;
        if (bus1.done) done_cnt1++;
    end

    // Full load on instance 0; optional stray starts and same-cycle read test.
    task automatic load0(input bit x, input bit inject, input bit rdtest);
        int   se;
        int   d0;
        bit   got;
        req_t r;
        @(negedge clk);
        se = cyc + 1;
        for (int j = 0; j < 16; j++) begin
            r.a = (x ? 13'h1000 : 13'h0000) + 13'(2 * j);
            r.c = se + 4 * j;
            q0.push_back(r);
        end
        d0 = done_cnt0;
        bus0.start = 1'b1;
        bus0.sel_x = x;
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            bus0.start = (inject && t == 10) ? 1'b1 : 1'b0;
            bus0.sel_x = inject ? ~x : x;
            if (t == 20) check("busy0_during", 32'(bus0.busy), 32'd1);
            if (rdtest && cyc == se + 3) begin
                bus0.buf_rd_en  = 1'b1;
                bus0.buf_rd_idx = 4'd0;
            end
            if (rdtest && cyc == se + 4) check("rd_same_cycle_old", 32'(bus0.buf_rd_data), 32'h0000);
            if (rdtest && cyc == se + 5) begin
                check("rd_next_cycle_new", 32'(bus0.buf_rd_data), 32'hA000);
                bus0.buf_rd_en = 1'b0;
            end
            if (bus0.done) begin
                got = 1'b1;
                check("done0_latency", cyc - se, 64);
                check("busy0_in_done", 32'(bus0.busy), 32'd0);
                if (inject) bus0.start = 1'b1;
            end
        end
        if (!got) check("done0_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus0.start = 1'b0;
        check("done0_one_cycle", 32'(bus0.done), 32'd0);
        repeat (8) @(negedge clk);
        check("req0_outstanding", q0.size(), 0);
        check("done0_count", done_cnt0 - d0, 1);
    endtask

    // Full W load on the banked instance.
    task automatic load1();
        int   se;
        bit   got;
        req_t r;
        @(negedge clk);
        se = cyc + 1;
        for (int j = 0; j < 8; j++) begin
            r.a = 13'(4 * j);
            r.c = se + 4 * j;
            q1.push_back(r);
        end
        bus1.start = 1'b1;
        bus1.sel_x = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            bus1.start = 1'b0;
            if (bus1.done) begin
                got = 1'b1;
                check("done1_latency", cyc - se, 32);
            end
        end
        if (!got) check("done1_timeout", 32'd0, 32'd1);
        repeat (4) @(negedge clk);
        check("req1_outstanding", q1.size(), 0);
        check("done1_count", done_cnt1, 1);
    endtask

    // One registered read, then confirm the value holds with rd_en low.
    task automatic rd(input bit u, input logic [3:0] idx, input logic [15:0] exp);
        @(negedge clk);
        if (u) begin bus1.buf_rd_en = 1'b1; bus1.buf_rd_idx = idx; end
        else   begin bus0.buf_rd_en = 1'b1; bus0.buf_rd_idx = idx; end
        @(negedge clk);
        bus0.buf_rd_en = 1'b0;
        bus1.buf_rd_en = 1'b0;
        check(u ? "rd1_data" : "rd0_data", 32'(u ? bus1.buf_rd_data : bus0.buf_rd_data), 32'(exp));
        @(negedge clk);
        check(u ? "rd1_hold" : "rd0_hold", 32'(u ? bus1.buf_rd_data : bus0.buf_rd_data), 32'(exp));
    endtask

    // Abort a W load with rst during its 4th request.
    task automatic reset_mid_load();
        int   se;
        req_t r;
        @(negedge clk);
        se = cyc + 1;
        for (int j = 0; j < 16; j++) begin
            r.a = 13'(2 * j);
            r.c = se + 4 * j;
            q0.push_back(r);
        end
        bus0.start = 1'b1;
        bus0.sel_x = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            bus0.start = 1'b0;
            if (cyc == se + 12) break;
        end
        check("rst_pre_read_en", 32'(bus0.mem_read_en), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_read_en", 32'(bus0.mem_read_en), 32'd0);
        check("rst_async_busy", 32'(bus0.busy), 32'd0);
        check("rst_async_done", 32'(bus0.done), 32'd0);
        q0.delete();
        repeat (2) @(negedge clk);
        check("rst_addr", 32'(bus0.mem_req_addr), 32'd0);
        check("rst_no_done", done_cnt0, 2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus0.start = 1'b0; bus0.sel_x = 1'b0; bus0.buf_rd_en = 1'b0; bus0.buf_rd_idx = '0;
        bus1.start = 1'b0; bus1.sel_x = 1'b0; bus1.buf_rd_en = 1'b0; bus1.buf_rd_idx = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus0.busy), 32'd0);
        check("reset_done", 32'(bus0.done), 32'd0);
        check("reset_read_en", 32'(bus0.mem_read_en), 32'd0);
        check("reset_addr", 32'(bus0.mem_req_addr), 32'd0);
        check("reset_rd_data", 32'(bus0.buf_rd_data), 32'd0);
        check("tied_write_en", 32'(bus0.mem_write_en), 32'd0);
        check("tied_req_data", 32'(bus0.mem_req_data), 32'd0);
        check("reset_busy1", 32'(bus1.busy), 32'd0);
        rst = 1'b0;

        load0(1'b0, 1'b1, 1'b0);
        rd(1'b0, 4'd5, 16'h0500);
        rd(1'b0, 4'd15, 16'h0F00);

        load0(1'b1, 1'b0, 1'b1);
        rd(1'b0, 4'd5, 16'hA005);
        rd(1'b0, 4'd15, 16'hA00F);

        reset_mid_load();
        load0(1'b0, 1'b0, 1'b0);
        rd(1'b0, 4'd5, 16'h0500);

        load1();
        rd(1'b1, 4'd2, 16'h0200);
        rd(1'b1, 4'd3, 16'h0300);
        rd(1'b1, 4'd15, 16'h0F00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Last-resort bound on total run time.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
